// File: rtl/truth_table_sweeper.sv
// Sweeps a 3-input gate through all eight input rows, captures its output
// into an 8-bit truth table and compares the table against EXPECTED.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECTED      = 8'hC7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] table_out
);

  localparam logic [7:0] CntMax = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] table_q, table_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    unique case (state_q)
      StIdle, StDone: begin
        // abort is deliberately ignored here; start always wins.
        if (start) begin
          state_d = StSettle;
          idx_d   = 3'd0;
          cnt_d   = 8'd0;
          table_d = 8'h00;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      StSettle: begin
        if (abort) begin
          state_d = StIdle;
          idx_d   = 3'd0;
          cnt_d   = 8'd0;
          table_d = 8'h00;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (cnt_q == CntMax) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StSample: begin
        if (abort) begin
          state_d = StIdle;
          idx_d   = 3'd0;
          cnt_d   = 8'd0;
          table_d = 8'h00;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          // Row 000 lands in bit 7, row 111 in bit 0.
          table_d[3'd7 - idx_q] = dut_out;
          if (idx_q == 3'd7) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (table_d == EXPECTED);
          end else begin
            state_d = StSettle;
            idx_d   = idx_q + 3'd1;
            cnt_d   = 8'd0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      cnt_q   <= 8'd0;
      table_q <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // idx stays at 7 in DONE, so the gate inputs hold 111 there.
  assign in1       = idx_q[2];
  assign in2       = idx_q[1];
  assign in3       = idx_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign table_out = table_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: default instance plus a
// SETTLE_CYCLES=1 instance, driven by a modelled 3-input gate.
module tb_truth_table_sweeper;

  logic       clk;
  logic       rst_n;
  logic       start, abort, dut_out;
  logic       in1, in2, in3, busy, done, pass;
  logic [7:0] table_out;

  logic       start_f, dut_out_f;
  logic       in1_f, in2_f, in3_f, busy_f, done_f, pass_f;
  logic [7:0] table_out_f;

  int unsigned n_checks;
  int unsigned n_errors;
  int          mode;  // 0: reference 0xC7 gate, 1: stuck-at-0, 2: row 010 inverted

  truth_table_sweeper dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .dut_out   (dut_out),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .table_out (table_out)
  );

  truth_table_sweeper #(
    .SETTLE_CYCLES (1),
    .EXPECTED      (8'hC7)
  ) dut_fast (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_f),
    .abort     (1'b0),
    .dut_out   (dut_out_f),
    .in1       (in1_f),
    .in2       (in2_f),
    .in3       (in3_f),
    .busy      (busy_f),
    .done      (done_f),
    .pass      (pass_f),
    .table_out (table_out_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic gate_ref(input logic [2:0] row);
    logic [7:0] t;
    t = 8'hC7;
    return t[3'd7 - row];
  endfunction

  always_comb begin
    dut_out = 1'b0;
    case (mode)
      0:       dut_out = gate_ref({in1, in2, in3});
      1:       dut_out = 1'b0;
      2:       dut_out = gate_ref({in1, in2, in3}) ^ ({in1, in2, in3} == 3'b010);
      default: dut_out = 1'b0;
    endcase
  end

  assign dut_out_f = gate_ref({in1_f, in2_f, in3_f});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulses start, then follows the sweep to done. extra_at re-pulses start
  // that many cycles after the accept edge (negative means never).
  task automatic run_sweep(input string tag, input int extra_at,
                           input logic [7:0] exp_tab, input logic exp_pass);
    int lat;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({tag, " accept busy"}, 32'(busy), 32'd1);
    check({tag, " accept done"}, 32'(done), 32'd0);
    check({tag, " accept pass"}, 32'(pass), 32'd0);
    check({tag, " accept table"}, 32'(table_out), 32'h00);
    check({tag, " accept ins"}, 32'({in1, in2, in3}), 32'd0);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      start = (lat == extra_at);
      if (!done && lat % 5 == 0) check({tag, " row ins"}, 32'({in1, in2, in3}), 32'(lat / 5));
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'd40);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " table"}, 32'(table_out), 32'(exp_tab));
    check({tag, " pass"}, 32'(pass), 32'(exp_pass));
    check({tag, " done ins"}, 32'({in1, in2, in3}), 32'd7);
  endtask

  initial begin
    int lat;
    n_checks = 0;
    n_errors = 0;
    mode     = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    start_f  = 1'b0;

    #3;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset pass", 32'(pass), 32'd0);
    check("reset table", 32'(table_out), 32'h00);
    check("reset ins", 32'({in1, in2, in3}), 32'd0);
    #9 rst_n = 1'b1;

    run_sweep("ref", -1, 8'hC7, 1'b1);

    // abort in DONE must not disturb the held result
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort in done: done", 32'(done), 32'd1);
    check("abort in done: table", 32'(table_out), 32'hC7);
    check("abort in done: pass", 32'(pass), 32'd1);

    mode = 1;
    run_sweep("stuck0", -1, 8'h00, 1'b0);
    mode = 2;
    run_sweep("row2 fault", -1, 8'hE7, 1'b0);
    mode = 0;
    run_sweep("start ignored", 3, 8'hC7, 1'b1);

    // abort during SETTLE of row 3 (rows start every 5 cycles)
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    check("pre-abort ins", 32'({in1, in2, in3}), 32'd3);
    check("pre-abort table", 32'(table_out), 32'hC0);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort pass", 32'(pass), 32'd0);
    check("abort table", 32'(table_out), 32'h00);
    check("abort ins", 32'({in1, in2, in3}), 32'd0);
    @(posedge clk); #1;
    check("abort stays idle", 32'(busy), 32'd0);
    run_sweep("after abort", -1, 8'hC7, 1'b1);

    // asynchronous reset during row 5
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (27) @(posedge clk);
    #1;
    check("pre-reset ins", 32'({in1, in2, in3}), 32'd5);
    rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset pass", 32'(pass), 32'd0);
    check("midreset table", 32'(table_out), 32'h00);
    check("midreset ins", 32'({in1, in2, in3}), 32'd0);
    #2 rst_n = 1'b1;
    run_sweep("after reset", -1, 8'hC7, 1'b1);

    // SETTLE_CYCLES=1 instance
    @(posedge clk); #1 start_f = 1'b1;
    @(posedge clk); #1 start_f = 1'b0;
    check("fast accept busy", 32'(busy_f), 32'd1);
    lat = 0;
    while (!done_f && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("fast latency", 32'(lat), 32'd16);
    check("fast table", 32'(table_out_f), 32'hC7);
    check("fast pass", 32'(pass_f), 32'd1);
    check("fast busy", 32'(busy_f), 32'd0);
    check("fast ins", 32'({in1_f, in2_f, in3_f}), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- SETTLE_CYCLES, 4, cycles each input combination is held before sampling; legal range 1..255.
- EXPECTED, 8'hC7, expected 8-bit truth table; bit 7 = row {in1,in2,in3}=000, bit 0 = row 111.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all state changes on its rising edge.
- rst_n, input, 1, reset; asynchronous assert, active-low.
- start, input, 1, begin a sweep; sampled on the rising edge of clk.
- abort, input, 1, cancel a sweep in progress.
- dut_out, input, 1, output of the 3-input gate under test.
- in1, in2, in3, output, 1 each, gate inputs; each is a register output.
- busy, output, 1, sweep in progress.
- done, output, 1, sweep complete; level, held until the next accepted start.
- pass, output, 1, captured table equals EXPECTED; valid only while done=1.
- table_out, output, 8, captured truth table in EXPECTED bit order.

Function
REQ-003 The block SHALL be an FSM with four states: IDLE, SETTLE, SAMPLE and DONE.
REQ-004 start=1 in IDLE or DONE SHALL take the FSM to SETTLE and, on the same edge, set:
- row index idx=0, so {in1,in2,in3}=000;
- settle counter=0;
- table_out=0, done=0, pass=0, busy=1.
REQ-005 start=1 in SETTLE or SAMPLE SHALL be ignored.
REQ-006 {in1,in2,in3} SHALL equal idx (in1 = MSB) at all times while busy=1.
REQ-007 SETTLE SHALL last exactly SETTLE_CYCLES cycles; the counter increments each cycle, and the FSM moves to SAMPLE when the counter reaches SETTLE_CYCLES-1.
REQ-008 SAMPLE SHALL last one cycle. On its closing edge, dut_out is written into table_out[7-idx]; then:
- if idx<7, idx increments, the settle counter clears and the FSM returns to SETTLE;
- if idx=7, the FSM moves to DONE.
REQ-009 On entry to DONE, on the same edge:
- done=1, busy=0;
- pass=1 if and only if the final table (including the row-7 sample) equals EXPECTED.
REQ-010 In DONE, in1/in2/in3 SHALL hold 111 and table_out SHALL hold its value until the next accepted start.
REQ-011 Latency: done SHALL rise exactly 8*(SETTLE_CYCLES+1) cycles after the start-accept edge; with the default, 40 cycles.
REQ-012 abort=1 in SETTLE or SAMPLE SHALL force IDLE on the next edge with busy=0, done=0, pass=0, {in1,in2,in3}=000 and table_out cleared. abort SHALL have no effect in IDLE or DONE.
REQ-013 If start and abort are both 1 in the same cycle:
- in SETTLE or SAMPLE, abort wins;
- in IDLE or DONE, start wins.
REQ-014 idx SHALL never wrap; the 8th sample always terminates the sweep.
REQ-015 dut_out SHALL be sampled only in SAMPLE; its value in every other state has no effect.

Reset
REQ-016 While rst_n=0, the block SHALL immediately (without waiting for a clock edge) set:
- state=IDLE, idx=0, settle counter=0;
- in1=in2=in3=0;
- busy=0, done=0, pass=0, table_out=8'h00.
REQ-017 Reset asserted mid-sweep SHALL discard all partial results. After rst_n deasserts, the first start SHALL begin a fresh sweep from row 000.

Verification
REQ-018 The bench SHALL cover at least these directed scenarios:
- Reference gate: dut_out modelled as the 0xC7 gate (rows 000,001,101,110,111 give 1; all other rows give 0), default parameters, start pulse -> done rises 40 cycles later, table_out=8'hC7, pass=1.
- Stuck-at-0: dut_out tied 0 -> table_out=8'h00, pass=0, done=1.
- Single-row fault: gate output inverted on row 010 only -> table_out=8'hE7, pass=0.
- Abort and restart: abort asserted during SETTLE of row 3 -> next cycle busy=0, done=0, table_out=0, inputs 000; a following start completes normally with table_out=8'hC7.
- Mid-sweep reset: rst_n pulsed low during row 5 -> all outputs reset immediately; restart yields table_out=8'hC7.
- Restart and timing: start pulsed during SETTLE is ignored (done timing unchanged); SETTLE_CYCLES=1 -> done rises 16 cycles after start; start while in DONE -> done drops on the accept edge and a new sweep runs.
